tile_seq_gen: RTL and testbench
===============================

// Module: tile_seq_gen
// PURPOSE
//  Responder side of the layer controller's tile interface. Accepts one layer geometry (cfg_valid/cfg_ready) and a start pulse.
//  Then walks the layer's output map in raster tiles, offering each tile's output and input windows on a valid/ready handshake.
//  Holds done once the last tile is acknowledged. Sits between the MobileNet layer controller and the conv1/dws runners.
// PARAMETERS
//  DIM_W  16  width of all dimension/coordinate fields; tile_in_row/col are DIM_W+1 signed
// PORTS
//  clk           in   1        clock; single clock domain
//  rst_n         in   1        reset, synchronous, active-low
//  cfg_valid     in   1        geometry valid; accepted when cfg_valid && cfg_ready
//  cfg_ready     out  1        1 in IDLE/ARMED/DONE, else 0
//  cfg_img_h/w   in   DIM_W    input feature-map height/width
//  cfg_tile_h/w  in   DIM_W    output tile height/width; 0 treated as 1
//  cfg_stride    in   DIM_W    1 => stride 1; any other value => stride 2
//  cfg_pad       in   DIM_W    symmetric zero padding
//  cfg_kernel    in   DIM_W    square kernel size
//  start         in   1        1-cycle pulse; begin tile walk
//  tile_valid    out  1        tile fields valid; held until tile_ready
//  tile_ready    in   1        consumer acknowledge; ignored while tile_valid=0
//  tile_out_row/col out DIM_W  tile origin in output map
//  tile_out_h/w  out  DIM_W    tile size in output pixels, clipped at map edge
//  tile_in_row/col out DIM_W+1 signed  input window origin (may be negative)
//  tile_in_h/w   out  DIM_W    input window size
//  tile_last     out  1        current tile is the final tile of the layer
//  done          out  1        level; set after last tile ack, cleared on next cfg accept
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE. Every output is 0 except cfg_ready=1. All counters and latched config are 0.
//  States: IDLE -> (cfg accept) ARMED -> (start) ISSUE <-> STEP -> DONE. DONE -> (cfg accept) ARMED; DONE -> (start) ISSUE, replaying the same config.
//  On cfg accept, latch all cfg fields. In the same cycle, register out_h = (img_h+2*pad-kernel)>>s + 1, where s = 0 or 1.
//   The numerator is computed in DIM_W+1 bits. If img+2*pad < kernel, out_h = 0. Same rule for out_w. Accept clears done.
//  cfg accept is legal in IDLE/ARMED/DONE; a later accept overwrites the earlier one. cfg_valid in ISSUE/STEP is ignored.
//  If start and cfg_valid are both high in ARMED/DONE, cfg is accepted and start is dropped. start in IDLE/ISSUE/STEP is ignored.
//  Start accepted at edge t: set out_row=out_col=0 and drive tile 0 fields. tile_valid=1 from edge t+1.
//   Exception: out_h or out_w is 0. Then go to DONE; done=1 from edge t+1 and tile_valid is never raised.
//  Tile fields: tile_out_h = min(tile_h, out_h-out_row); tile_in_row = (out_row<<s) - pad (signed).
//   tile_in_h = ((tile_out_h-1)<<s) + kernel. Same for columns.
//  In ISSUE, tile_valid=1 and all tile fields are stable until tile_valid && tile_ready at an edge.
//  That edge moves to STEP: tile_valid=0 for exactly one cycle while counters advance.
//   Column-inner order: out_col += tile_w. At or past out_w, out_col=0 and out_row += tile_h.
//  STEP returns to ISSUE with the new fields; tile_valid=1 on the following edge.
//  If the acknowledged tile had tile_last=1, go ISSUE -> DONE directly: done=1 next cycle, tile_valid=0.
//  tile_last = 1 when out_row+tile_h >= out_h and out_col+tile_w >= out_w.
//  Counters and sums are computed one bit wider than DIM_W; no wrap for dims < 2^DIM_W.
//  rst_n low mid-walk: synchronous return to reset values next edge; no tile outstanding afterwards.
// TESTING
//  224x224, tile 16x16, stride 2, pad 1, k 3, start -> 49 tiles, out 112x112.
//   Tile 0: in_row=-1, in_h=33, out_h=16. Last tile: out_row=96, out_col=96, in_row=191, tile_last=1. Then done=1.
//  20x20, tile 16, stride 1, pad 1, k 3 -> 4 tiles. Tile (16,16): out_h=out_w=4, in_row=15, in_h=6.
//  14x14, tile 16, stride 1 -> single tile: out 14x14, in_row=-1, in_h=16, tile_last=1.
//  img 0x0, pad 0, k 3 -> done=1 one cycle after start; tile_valid stays 0.
//  Hold tile_ready low 10 cycles -> tile_valid and fields stable. Pulse tile_ready -> 1-cycle tile_valid=0 bubble.
//   Also: tile_ready while tile_valid=0 ignored; start and cfg_valid in the same cycle -> cfg accepted, no walk.
//  Assert rst_n=0 for 1 cycle mid-walk -> all outputs reset, cfg_ready=1. New cfg+start -> walk restarts at tile 0.

Source files
------------

// File: rtl/tile_seq_gen.sv
// Tile sequencer: latches one layer geometry, then walks the output map in raster
// tiles, presenting each tile's output and input windows on a valid/ready handshake.
module tile_seq_gen #(
    parameter int unsigned DIM_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [DIM_W-1:0]       cfg_img_h,
    input  logic [DIM_W-1:0]       cfg_img_w,
    input  logic [DIM_W-1:0]       cfg_tile_h,
    input  logic [DIM_W-1:0]       cfg_tile_w,
    input  logic [DIM_W-1:0]       cfg_stride,
    input  logic [DIM_W-1:0]       cfg_pad,
    input  logic [DIM_W-1:0]       cfg_kernel,
    input  logic                   start,
    output logic                   tile_valid,
    input  logic                   tile_ready,
    output logic [DIM_W-1:0]       tile_out_row,
    output logic [DIM_W-1:0]       tile_out_col,
    output logic [DIM_W-1:0]       tile_out_h,
    output logic [DIM_W-1:0]       tile_out_w,
    output logic signed [DIM_W:0]  tile_in_row,
    output logic signed [DIM_W:0]  tile_in_col,
    output logic [DIM_W-1:0]       tile_in_h,
    output logic [DIM_W-1:0]       tile_in_w,
    output logic                   tile_last,
    output logic                   done
);

    localparam int unsigned W1 = DIM_W + 1;
    localparam int unsigned W2 = DIM_W + 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_ISSUE = 3'd2,
        S_STEP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Output map dimension: (img + 2*pad - kernel) >> s, plus one; zero if the kernel does not fit.
    function automatic logic [W1-1:0] f_out_dim(input logic [DIM_W-1:0] img,
                                                 input logic [DIM_W-1:0] pad,
                                                 input logic [DIM_W-1:0] kernel,
                                                 input logic             s);
        logic [W1-1:0] sum;
        logic [W1-1:0] num;
        sum = W1'(img) + (W1'(pad) << 1);
        num = sum - W1'(kernel);
        if (sum < W1'(kernel)) begin
            return '0;
        end
        return (num >> s) + W1'(1);
    endfunction

    function automatic logic [DIM_W-1:0] f_tile_out(input logic [W1-1:0]    dim,
                                                    input logic [W1-1:0]    pos,
                                                    input logic [DIM_W-1:0] tile);
        logic [W1-1:0] rem;
        rem = dim - pos;
        return (W1'(tile) < rem) ? tile : DIM_W'(rem);
    endfunction

    function automatic logic [W1-1:0] f_in_org(input logic [W1-1:0]    pos,
                                               input logic             s,
                                               input logic [DIM_W-1:0] pad);
        logic [W1-1:0] scaled;
        scaled = s ? (pos << 1) : pos;
        return scaled - W1'(pad);
    endfunction

    function automatic logic [DIM_W-1:0] f_in_size(input logic [DIM_W-1:0] tout,
                                                   input logic             s,
                                                   input logic [DIM_W-1:0] kernel);
        logic [W1-1:0] span;
        span = W1'(tout) - W1'(1);
        return DIM_W'((s ? (span << 1) : span) + W1'(kernel));
    endfunction

    function automatic logic f_reach(input logic [W1-1:0]    pos,
                                     input logic [DIM_W-1:0] tile,
                                     input logic [W1-1:0]    dim);
        return (W2'(pos) + W2'(tile)) >= W2'(dim);
    endfunction

    state_t            r_state;
    state_t            w_nx_state;

    logic [DIM_W-1:0]  r_tile_h, r_tile_w, r_pad, r_kernel;
    logic [DIM_W-1:0]  w_nx_tile_h, w_nx_tile_w, w_nx_pad, w_nx_kernel;
    logic              r_s, w_nx_s;
    logic [W1-1:0]     r_out_h, r_out_w, r_row, r_col;
    logic [W1-1:0]     w_nx_out_h, w_nx_out_w, w_nx_row, w_nx_col;

    logic              r_cfg_ready, r_tile_valid, r_last, r_done;
    logic              w_nx_cfg_ready, w_nx_tile_valid, w_nx_last, w_nx_done;
    logic [DIM_W-1:0]  r_o_row, r_o_col, r_o_h, r_o_w, r_i_h, r_i_w;
    logic [DIM_W-1:0]  w_nx_o_row, w_nx_o_col, w_nx_o_h, w_nx_o_w, w_nx_i_h, w_nx_i_w;
    logic [W1-1:0]     r_i_row, r_i_col;
    logic [W1-1:0]     w_nx_i_row, w_nx_i_col;

    // Candidate config on the cfg bus
    logic              w_cfg_s;
    logic [DIM_W-1:0]  w_cfg_tile_h, w_cfg_tile_w;
    logic [W1-1:0]     w_cfg_out_h, w_cfg_out_w;

    // Fields of the tile about to be presented: tile 0 on start, the advanced position from STEP
    logic [W1-1:0]     w_pos_row, w_pos_col;
    logic [DIM_W-1:0]  w_tout_h, w_tout_w, w_tin_h, w_tin_w;
    logic [W1-1:0]     w_tin_row, w_tin_col;
    logic              w_tlast;

    logic [W2-1:0]     w_col_sum;
    logic              w_col_wrap;
    logic [W1-1:0]     w_row_adv, w_col_adv;

    assign w_cfg_s      = (cfg_stride != DIM_W'(1));
    assign w_cfg_tile_h = (cfg_tile_h == '0) ? DIM_W'(1) : cfg_tile_h;
    assign w_cfg_tile_w = (cfg_tile_w == '0) ? DIM_W'(1) : cfg_tile_w;
    assign w_cfg_out_h  = f_out_dim(cfg_img_h, cfg_pad, cfg_kernel, w_cfg_s);
    assign w_cfg_out_w  = f_out_dim(cfg_img_w, cfg_pad, cfg_kernel, w_cfg_s);

    assign w_pos_row = (r_state == S_STEP) ? r_row : '0;
    assign w_pos_col = (r_state == S_STEP) ? r_col : '0;
    assign w_tout_h  = f_tile_out(r_out_h, w_pos_row, r_tile_h);
    assign w_tout_w  = f_tile_out(r_out_w, w_pos_col, r_tile_w);
    assign w_tin_row = f_in_org(w_pos_row, r_s, r_pad);
    assign w_tin_col = f_in_org(w_pos_col, r_s, r_pad);
    assign w_tin_h   = f_in_size(w_tout_h, r_s, r_kernel);
    assign w_tin_w   = f_in_size(w_tout_w, r_s, r_kernel);
    assign w_tlast   = f_reach(w_pos_row, r_tile_h, r_out_h) && f_reach(w_pos_col, r_tile_w, r_out_w);

    // Column-inner raster advance
    assign w_col_sum  = W2'(r_col) + W2'(r_tile_w);
    assign w_col_wrap = (w_col_sum >= W2'(r_out_w));
    assign w_col_adv  = w_col_wrap ? '0 : W1'(w_col_sum);
    assign w_row_adv  = w_col_wrap ? (r_row + W1'(r_tile_h)) : r_row;

    // Next-state and next-output logic
    always_comb begin
        w_nx_state      = r_state;
        w_nx_tile_h     = r_tile_h;
        w_nx_tile_w     = r_tile_w;
        w_nx_pad        = r_pad;
        w_nx_kernel     = r_kernel;
        w_nx_s          = r_s;
        w_nx_out_h      = r_out_h;
        w_nx_out_w      = r_out_w;
        w_nx_row        = r_row;
        w_nx_col        = r_col;
        w_nx_tile_valid = r_tile_valid;
        w_nx_last       = r_last;
        w_nx_done       = r_done;
        w_nx_o_row      = r_o_row;
        w_nx_o_col      = r_o_col;
        w_nx_o_h        = r_o_h;
        w_nx_o_w        = r_o_w;
        w_nx_i_row      = r_i_row;
        w_nx_i_col      = r_i_col;
        w_nx_i_h        = r_i_h;
        w_nx_i_w        = r_i_w;

        case (r_state)
            S_IDLE, S_ARMED, S_DONE: begin
                if (cfg_valid) begin
                    w_nx_state  = S_ARMED;
                    w_nx_tile_h = w_cfg_tile_h;
                    w_nx_tile_w = w_cfg_tile_w;
                    w_nx_pad    = cfg_pad;
                    w_nx_kernel = cfg_kernel;
                    w_nx_s      = w_cfg_s;
                    w_nx_out_h  = w_cfg_out_h;
                    w_nx_out_w  = w_cfg_out_w;
                    w_nx_done   = 1'b0;
                end else if (start && (r_state != S_IDLE)) begin
                    w_nx_row = '0;
                    w_nx_col = '0;
                    if ((r_out_h == '0) || (r_out_w == '0)) begin
                        w_nx_state = S_DONE;
                        w_nx_done  = 1'b1;
                    end else begin
                        w_nx_state      = S_ISSUE;
                        w_nx_tile_valid = 1'b1;
                        w_nx_o_row      = DIM_W'(w_pos_row);
                        w_nx_o_col      = DIM_W'(w_pos_col);
                        w_nx_o_h        = w_tout_h;
                        w_nx_o_w        = w_tout_w;
                        w_nx_i_row      = w_tin_row;
                        w_nx_i_col      = w_tin_col;
                        w_nx_i_h        = w_tin_h;
                        w_nx_i_w        = w_tin_w;
                        w_nx_last       = w_tlast;
                    end
                end
            end
            S_ISSUE: begin
                if (tile_ready) begin
                    w_nx_tile_valid = 1'b0;
                    if (r_last) begin
                        w_nx_state = S_DONE;
                        w_nx_done  = 1'b1;
                    end else begin
                        w_nx_state = S_STEP;
                        w_nx_row   = w_row_adv;
                        w_nx_col   = w_col_adv;
                    end
                end
            end
            S_STEP: begin
                w_nx_state      = S_ISSUE;
                w_nx_tile_valid = 1'b1;
                w_nx_o_row      = DIM_W'(w_pos_row);
                w_nx_o_col      = DIM_W'(w_pos_col);
                w_nx_o_h        = w_tout_h;
                w_nx_o_w        = w_tout_w;
                w_nx_i_row      = w_tin_row;
                w_nx_i_col      = w_tin_col;
                w_nx_i_h        = w_tin_h;
                w_nx_i_w        = w_tin_w;
                w_nx_last       = w_tlast;
            end
            default: begin
                w_nx_state = S_IDLE;
            end
        endcase

        w_nx_cfg_ready = (w_nx_state == S_IDLE) || (w_nx_state == S_ARMED) || (w_nx_state == S_DONE);
    end

    // State, config, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_tile_h     <= '0;
            r_tile_w     <= '0;
            r_pad        <= '0;
            r_kernel     <= '0;
            r_s          <= 1'b0;
            r_out_h      <= '0;
            r_out_w      <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_cfg_ready  <= 1'b1;
            r_tile_valid <= 1'b0;
            r_last       <= 1'b0;
            r_done       <= 1'b0;
            r_o_row      <= '0;
            r_o_col      <= '0;
            r_o_h        <= '0;
            r_o_w        <= '0;
            r_i_row      <= '0;
            r_i_col      <= '0;
            r_i_h        <= '0;
            r_i_w        <= '0;
        end else begin
            r_state      <= w_nx_state;
            r_tile_h     <= w_nx_tile_h;
            r_tile_w     <= w_nx_tile_w;
            r_pad        <= w_nx_pad;
            r_kernel     <= w_nx_kernel;
            r_s          <= w_nx_s;
            r_out_h      <= w_nx_out_h;
            r_out_w      <= w_nx_out_w;
            r_row        <= w_nx_row;
            r_col        <= w_nx_col;
            r_cfg_ready  <= w_nx_cfg_ready;
            r_tile_valid <= w_nx_tile_valid;
            r_last       <= w_nx_last;
            r_done       <= w_nx_done;
            r_o_row      <= w_nx_o_row;
            r_o_col      <= w_nx_o_col;
            r_o_h        <= w_nx_o_h;
            r_o_w        <= w_nx_o_w;
            r_i_row      <= w_nx_i_row;
            r_i_col      <= w_nx_i_col;
            r_i_h        <= w_nx_i_h;
            r_i_w        <= w_nx_i_w;
        end
    end

    assign cfg_ready    = r_cfg_ready;
    assign tile_valid   = r_tile_valid;
    assign tile_out_row = r_o_row;
    assign tile_out_col = r_o_col;
    assign tile_out_h   = r_o_h;
    assign tile_out_w   = r_o_w;
    assign tile_in_row  = r_i_row;
    assign tile_in_col  = r_i_col;
    assign tile_in_h    = r_i_h;
    assign tile_in_w    = r_i_w;
    assign tile_last    = r_last;
    assign done         = r_done;

endmodule

// File: tb/tb_tile_seq_gen.sv
// Bench for tile_seq_gen: directed geometries plus random configs and back-pressure,
// checked against a tile list computed from the layer geometry.
module tb_tile_seq_gen;

    logic               clk;
    logic               rst_n;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [15:0]        cfg_img_h, cfg_img_w, cfg_tile_h, cfg_tile_w, cfg_stride, cfg_pad, cfg_kernel;
    logic               start;
    logic               tile_valid;
    logic               tile_ready;
    logic [15:0]        tile_out_row, tile_out_col, tile_out_h, tile_out_w;
    logic signed [16:0] tile_in_row, tile_in_col;
    logic [15:0]        tile_in_h, tile_in_w;
    logic               tile_last;
    logic               done;

    tile_seq_gen #(.DIM_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_img_h(cfg_img_h), .cfg_img_w(cfg_img_w),
        .cfg_tile_h(cfg_tile_h), .cfg_tile_w(cfg_tile_w),
        .cfg_stride(cfg_stride), .cfg_pad(cfg_pad), .cfg_kernel(cfg_kernel),
        .start(start),
        .tile_valid(tile_valid), .tile_ready(tile_ready),
        .tile_out_row(tile_out_row), .tile_out_col(tile_out_col),
        .tile_out_h(tile_out_h), .tile_out_w(tile_out_w),
        .tile_in_row(tile_in_row), .tile_in_col(tile_in_col),
        .tile_in_h(tile_in_h), .tile_in_w(tile_in_w),
        .tile_last(tile_last), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int orow, ocol, oh, ow, irow, icol, ih, iw;
        bit last;
    } tile_t;

    tile_t q[$];
    int    total, bad;
    int    m_out_h, m_out_w, m_th, m_tw, m_s, m_pad, m_k;
    bit    m_done;

    int          n_tiles;
    logic [16:0] f_irow, l_irow;
    logic [15:0] f_ih, f_oh, l_orow, l_ocol, l_oh, l_ih;
    logic        l_last;

    logic [130:0] w_obs;
    assign w_obs = {tile_out_row, tile_out_col, tile_out_h, tile_out_w,
                    tile_in_row, tile_in_col, tile_in_h, tile_in_w, tile_last};

    function automatic int out_dim(int img, int pad, int k, int s);
        if (img + 2 * pad < k) return 0;
        return ((img + 2 * pad - k) >> s) + 1;
    endfunction

    function automatic void build_tiles();
        q.delete();
        for (int r = 0; r < m_out_h; r += m_th) begin
            for (int c = 0; c < m_out_w; c += m_tw) begin
                tile_t t;
                t.orow = r;
                t.ocol = c;
                t.oh   = (m_th < m_out_h - r) ? m_th : m_out_h - r;
                t.ow   = (m_tw < m_out_w - c) ? m_tw : m_out_w - c;
                t.irow = (r << m_s) - m_pad;
                t.icol = (c << m_s) - m_pad;
                t.ih   = ((t.oh - 1) << m_s) + m_k;
                t.iw   = ((t.ow - 1) << m_s) + m_k;
                t.last = (r + m_th >= m_out_h) && (c + m_tw >= m_out_w);
                q.push_back(t);
            end
        end
    endfunction

    function automatic logic [130:0] pack_exp(tile_t t);
        return {16'(t.orow), 16'(t.ocol), 16'(t.oh), 16'(t.ow),
                17'(t.irow), 17'(t.icol), 16'(t.ih), 16'(t.iw), t.last};
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [130:0] obs, input logic [130:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset();
        chk1("rst_valid", tile_valid, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_cfg_ready", cfg_ready, 1'b1);
        chkv("rst_fields", w_obs, 131'(0));
    endtask

    task automatic do_cfg(input int ih, input int iw, input int th, input int tw,
                          input int st, input int pd, input int k, input bit with_start);
        cfg_img_h  = 16'(ih);
        cfg_img_w  = 16'(iw);
        cfg_tile_h = 16'(th);
        cfg_tile_w = 16'(tw);
        cfg_stride = 16'(st);
        cfg_pad    = 16'(pd);
        cfg_kernel = 16'(k);
        cfg_valid  = 1'b1;
        start      = with_start;
        @(negedge clk);
        cfg_valid = 1'b0;
        start     = 1'b0;
        m_th    = (th == 0) ? 1 : th;
        m_tw    = (tw == 0) ? 1 : tw;
        m_s     = (st == 1) ? 0 : 1;
        m_pad   = pd;
        m_k     = k;
        m_out_h = out_dim(ih, pd, k, m_s);
        m_out_w = out_dim(iw, pd, k, m_s);
        m_done  = 1'b0;
        chk1("cfg_ready", cfg_ready, 1'b1);
        chk1("cfg_valid_lo", tile_valid, 1'b0);
        chk1("cfg_done_clr", done, 1'b0);
    endtask

    // Pulse start and follow the walk; abort_at >= 0 applies a one-cycle reset at that tile.
    task automatic walk(input bit stall, input int abort_at);
        int idx    = 0;
        int cyc    = 0;
        int st_cnt = 0;
        bit acked;
        build_tiles();
        n_tiles    = 0;
        start      = 1'b1;
        tile_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        if (q.size() == 0) begin
            m_done = 1'b1;
            repeat (3) begin
                chk1("empty_valid", tile_valid, 1'b0);
                chk1("empty_done", done, 1'b1);
                chk1("empty_cfg_ready", cfg_ready, 1'b1);
                @(negedge clk);
            end
            return;
        end
        forever begin
            chk1("tile_valid", tile_valid, 1'b1);
            chkv($sformatf("tile%0d_fields", idx), w_obs, pack_exp(q[idx]));
            chk1("busy_cfg_ready", cfg_ready, 1'b0);
            chk1("busy_done", done, m_done);
            if (idx == abort_at) begin
                rst_n      = 1'b0;
                tile_ready = 1'b0;
                cfg_valid  = 1'b0;
                @(negedge clk);
                rst_n   = 1'b1;
                m_done  = 1'b0;
                m_out_h = 0;
                m_out_w = 0;
                chk_reset();
                return;
            end
            if (stall && idx == 0 && st_cnt < 10) begin
                tile_ready = 1'b0;
                st_cnt++;
            end else begin
                tile_ready = 1'($urandom_range(0, 1));
            end
            cfg_valid = ($urandom_range(0, 7) == 0);
            acked     = tile_ready;
            if (acked) begin
                if (idx == 0) begin
                    f_irow = tile_in_row;
                    f_ih   = tile_in_h;
                    f_oh   = tile_out_h;
                end
                l_orow = tile_out_row;
                l_ocol = tile_out_col;
                l_irow = tile_in_row;
                l_oh   = tile_out_h;
                l_ih   = tile_in_h;
                l_last = tile_last;
                n_tiles++;
            end
            @(negedge clk);
            cyc++;
            if (acked) begin
                if (q[idx].last) begin
                    cfg_valid  = 1'b0;
                    tile_ready = 1'b0;
                    m_done     = 1'b1;
                    chk1("end_valid", tile_valid, 1'b0);
                    chk1("end_done", done, 1'b1);
                    chk1("end_cfg_ready", cfg_ready, 1'b1);
                    break;
                end
                chk1("bubble_valid", tile_valid, 1'b0);
                chk1("bubble_cfg_ready", cfg_ready, 1'b0);
                tile_ready = 1'($urandom_range(0, 1));
                cfg_valid  = ($urandom_range(0, 7) == 0);
                @(negedge clk);
                cyc++;
                idx++;
            end
            if (cyc > 20000) begin
                total++;
                bad++;
                $error("FAIL walk_timeout: cycles=%0d required<=20000", cyc);
                cfg_valid  = 1'b0;
                tile_ready = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        cfg_valid = 1'b0;
        start = 1'b0;
        tile_ready = 1'b0;
        cfg_img_h = '0; cfg_img_w = '0; cfg_tile_h = '0; cfg_tile_w = '0;
        cfg_stride = '0; cfg_pad = '0; cfg_kernel = '0;
        repeat (2) @(negedge clk);
        chk_reset();
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset();

        // start in IDLE does nothing
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk1("idle_start_valid", tile_valid, 1'b0);
        chk1("idle_start_ready", cfg_ready, 1'b1);

        // 224x224 stride 2, with a 10-cycle stall on tile 0
        do_cfg(224, 224, 16, 16, 2, 1, 3, 1'b0);
        walk(1'b1, -1);
        chkv("n224", 131'(n_tiles), 131'(49));
        chkv("t0_in_row", 131'(f_irow), 131'(17'h1FFFF));
        chkv("t0_in_h", 131'(f_ih), 131'(33));
        chkv("t0_out_h", 131'(f_oh), 131'(16));
        chkv("tl_out_row", 131'(l_orow), 131'(96));
        chkv("tl_out_col", 131'(l_ocol), 131'(96));
        chkv("tl_in_row", 131'(l_irow), 131'(191));
        chk1("tl_last", l_last, 1'b1);

        // replay from DONE
        walk(1'b0, -1);
        chkv("n224_replay", 131'(n_tiles), 131'(49));

        do_cfg(20, 20, 16, 16, 1, 1, 3, 1'b0);
        walk(1'b0, -1);
        chkv("n20", 131'(n_tiles), 131'(4));
        chkv("t20_out_h", 131'(l_oh), 131'(4));
        chkv("t20_in_row", 131'(l_irow), 131'(15));
        chkv("t20_in_h", 131'(l_ih), 131'(6));

        do_cfg(14, 14, 16, 16, 1, 1, 3, 1'b0);
        walk(1'b0, -1);
        chkv("n14", 131'(n_tiles), 131'(1));
        chkv("t14_out_h", 131'(f_oh), 131'(14));
        chkv("t14_in_row", 131'(f_irow), 131'(17'h1FFFF));
        chkv("t14_in_h", 131'(f_ih), 131'(16));
        chk1("t14_last", l_last, 1'b1);

        // empty output map
        do_cfg(0, 0, 16, 16, 1, 0, 3, 1'b0);
        walk(1'b0, -1);
        chkv("n_empty", 131'(n_tiles), 131'(0));

        // cfg and start together in ARMED: cfg wins, no walk
        do_cfg(20, 20, 8, 8, 1, 1, 3, 1'b0);
        do_cfg(30, 30, 8, 8, 2, 0, 3, 1'b1);
        repeat (3) begin
            chk1("cfg_start_valid", tile_valid, 1'b0);
            chk1("cfg_start_ready", cfg_ready, 1'b1);
            @(negedge clk);
        end
        walk(1'b0, -1);
        chkv("n30", 131'(n_tiles), 131'(4));

        // random geometries
        repeat (6) begin
            int ih, iw, th, tw, st, pd, k;
            ih = $urandom_range(1, 30);
            iw = $urandom_range(1, 30);
            th = $urandom_range(0, 10);
            tw = $urandom_range(0, 10);
            st = $urandom_range(0, 3);
            pd = $urandom_range(0, 2);
            k  = $urandom_range(1, 5);
            do_cfg(ih, iw, th, tw, st, pd, k, 1'b0);
            walk(1'b0, -1);
        end

        // reset mid-walk, then restart from tile 0
        do_cfg(224, 224, 16, 16, 2, 1, 3, 1'b0);
        walk(1'b0, 5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk1("post_rst_start_valid", tile_valid, 1'b0);
        chk1("post_rst_ready", cfg_ready, 1'b1);
        do_cfg(40, 24, 16, 16, 1, 1, 3, 1'b0);
        walk(1'b0, -1);
        chkv("n_after_rst", 131'(n_tiles), 131'(6));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
